btn_debounce_bank: RTL
======================

// Module: btn_debounce_bank
// PURPOSE
//  Conditions N_BTN raw push-button inputs into clean, clock-synchronous signals for the reaction-timer control FSM.
//  Feeds that FSM's start/clear/stop button inputs.
//  Per channel: 2-flop synchroniser, counter-based debounce FSM, one-cycle press/release pulses.
//  Channels are fully independent; the bank is N_BTN copies of one channel sub-module.
// PARAMETERS
//  N_BTN      3          number of button channels
//  DB_CYCLES  2_000_000  stable-sample count needed to accept a level change (20 ms @ 100 MHz); must be >= 2
//  CNT_W      $clog2(DB_CYCLES)  debounce counter width (derived, not overridden)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous, active-low reset (rst==0 resets on next clk edge)
//  btn_raw    in   N_BTN  asynchronous raw button levels, 1 = pressed
//  btn_level  out  N_BTN  debounced level
//  btn_press  out  N_BTN  1-cycle pulse on accepted 0->1 change
//  btn_rel    out  N_BTN  1-cycle pulse on accepted 1->0 change
// BEHAVIOUR
//  - Reset (rst==0 at edge): sync flops=0, state=IDLE_LO, cnt=0, btn_level=0, btn_press=0, btn_rel=0.
//  - Sync: s1<=btn_raw[i]; s2<=s1. The FSM sees only s2.
//  - FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
//    IDLE_LO: s2==1 -> WAIT_HI, cnt<=0.
//    WAIT_HI: s2==0 -> IDLE_LO, cnt<=0 (glitch rejected).
//             s2==1 && cnt<DB_CYCLES-1 -> cnt<=cnt+1.
//             s2==1 && cnt==DB_CYCLES-1 -> IDLE_HI, level<=1, press<=1.
//    IDLE_HI / WAIT_LO: mirror image; commit gives level<=0, rel<=1.
//  - btn_level, btn_press and btn_rel are all registered; press/rel are high for exactly one cycle per commit.
//  - Latency: raw change first sampled at edge E0 -> outputs update at edge E0+DB_CYCLES+2.
//    Acceptance needs raw stable for DB_CYCLES+1 consecutive samples; DB_CYCLES or fewer samples are rejected.
//  - Counter saturates by construction; it never wraps. It is cleared on every return to an IDLE state.
//  - Bounce inside WAIT_* restarts the qualification from IDLE, not from a partial count.
//  - press and rel are never both asserted on one channel in the same cycle.
//  - Channels may commit in the same cycle; there is no priority or interaction between them.
//  - Reset mid-WAIT aborts: no pulse, level=0.
//  - Button held through reset release: treated as a fresh press, so press fires DB_CYCLES+2 edges after the release.
// STRUCTURE
//  - Shared package btn_pkg: typedef enum logic [1:0] db_state_t {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO}.
//  - Sub-module btn_debounce_ch: one channel (sync + FSM + counter); parameter DB_CYCLES.
//    Ports: clk, rst, raw, level, press, rel.
//  - Top: generate loop of N_BTN btn_debounce_ch instances. No logic at top level beyond the loop.
// TESTING (DB_CYCLES=4, N_BTN=3)
//  - Reset held 3 cycles with btn_raw=3'b111 -> all outputs 0; release rst -> press=3'b111 exactly 6 edges after release, level=3'b111.
//  - btn_raw[0] high for 4 cycles then low -> no press, level[0] stays 0.
//  - btn_raw[0] high for 5 cycles -> one press[0] pulse; then low 10 cycles -> one rel[0] pulse 6 edges after the fall.
//  - Bounce pattern 1,0,1,1,0,1,1,1,1,1 on btn_raw[1] -> exactly one press[1], fired 6 edges after the final rise.
//  - btn_raw[0] and btn_raw[2] rise on the same edge -> press[0] and press[2] in the same cycle; channel 1 untouched.
//  - rst asserted in WAIT_HI, 2 cycles before commit -> no press; level=0 after reset.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types for the push-button debounce bank.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package btn_pkg;

   // Per-channel debounce state: two stable levels, each with a qualification state.
   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } db_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, counter-qualified FSM, press/release pulses.
// Latency: a raw change first sampled at edge E0 reaches the outputs at edge E0+DB_CYCLES+2.
// Backpressure: none; outputs are free-running levels and one-cycle pulses.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DB_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int              CNT_W   = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   db_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;

   // Bring the asynchronous button level into the clock domain; the FSM only sees sync2_q.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // State, qualification counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   // Next state: a level change must hold for DB_CYCLES+1 samples; any bounce restarts from IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
         IDLE_LO: begin
            if (sync2_q) begin
               state_d = WAIT_HI;
               cnt_d   = '0;
            end
         end
         WAIT_HI: begin
            if (!sync2_q) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IDLE_HI: begin
            if (!sync2_q) begin
               state_d = WAIT_LO;
               cnt_d   = '0;
            end
         end
         WAIT_LO: begin
            if (sync2_q) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   assign level = level_q;
   assign press = press_q;
   assign rel   = rel_q;

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of N_BTN independent button debounce channels.
// Latency: DB_CYCLES+2 edges from first sample of a raw change to the outputs.
// Backpressure: none; channels commit independently, possibly in the same cycle.
module btn_debounce_bank #(
   parameter int N_BTN     = 3,
   parameter int DB_CYCLES = 2_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_rel
);

   // One self-contained channel per button; no cross-channel logic.
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DB_CYCLES (DB_CYCLES)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .press (btn_press[i]),
         .rel   (btn_rel[i])
      );
   end

endmodule
